serial_adder: RTL and testbench

- Multi-cycle, parametrised adder built from one SLICE-bit adder stage that is reused every cycle.
- Adds two WIDTH-bit operands plus a carry-in, SLICE bits per clock, LSB slice first. The carry is held in a flop between slices.
- Successor to the single-bit combinational full adder. Trades latency for area and adds valid/ready handshakes on both input and output, so it can sit between the lab's operand registers and the display/result stage.

---
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder that reuses one SLICE-bit adder
// stage per clock, LSB slice first, with valid/ready handshakes on both sides.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which adds
// the input port sub (a - b computed as a + ~b + 1).
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_d;
  logic              carry_q, cout_q;
  logic [SLICE-1:0]  a_sl, b_sl;
  logic [SLICE:0]    slice_res;
  logic              last_slice;
  logic              accept;
  logic [WIDTH-1:0]  b_load;
  logic              carry_load;

  assign last_slice = (cnt == CW'(N - 1));
  assign accept     = (state == IDLE) && in_valid;

  // Outputs are decoded from state or driven by registers only.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

  // Operand B and initial carry as loaded at acceptance (inverted B and carry 1 when subtracting).
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : c_in;
  end
`else
  always_comb begin
    b_load     = b;
    carry_load = c_in;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Slice adder: select slice cnt of the operands, add with the carry flop,
  // and merge the slice result back into the matching bits of the sum.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (CW'(k) == cnt) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    sum_d = sum_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (CW'(k) == cnt) sum_d[k*SLICE +: SLICE] = slice_res[SLICE-1:0];
    end
  end

  // Datapath registers: operand capture on accept, one slice per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_load;
      sum_q   <= '0;
      carry_q <= carry_load;
      cnt     <= '0;
    end else if (state == RUN) begin
      sum_q   <= sum_d;
      carry_q <= slice_res[SLICE];
      if (last_slice) begin
        cout_q <= slice_res[SLICE];
        cnt    <= '0;
      end else begin
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed plan cases plus randomized
// transactions checked against an arithmetic reference model. Covers an
// 8-bit/1-bit-slice instance and a 16-bit/4-bit-slice instance.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit, 1 bit per cycle instance
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, carry_out, busy;
  logic [7:0] a = '0, b = '0, sum;
  logic       c_in = 1'b0;
  logic       sub = 1'b0;

  serial_adder #(.WIDTH(8), .SLICE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  // 16-bit, 4 bits per cycle instance
  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1, carry_out16, busy16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        c_in16 = 1'b0;
  logic        sub16 = 1'b0;

  serial_adder #(.WIDTH(16), .SLICE(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .c_in(c_in16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .carry_out(carry_out16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the 8-bit instance. hold = cycles out_ready stays low
  // after completion; junk = drive stray in_valid/operands during RUN and DONE.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit tc,
                      input bit tsub, input int hold, input bit junk);
    logic [8:0] exp;
    int lat, busy_cnt, guard;
    if (SUB_EN && tsub) begin
      exp[7:0] = ta - tb;
      exp[8]   = (ta >= tb);
    end else begin
      exp = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
    end
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("idle_ready", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb; c_in = tc; sub = tsub; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      if (in_ready) break;
      if (junk) begin
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
      end
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'd8);
    check("busy_cycles", 64'(busy_cnt), 64'd8);
    check("sum", {56'd0, sum}, {56'd0, exp[7:0]});
    check("carry_out", {63'd0, carry_out}, {63'd0, exp[8]});
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      end
      @(posedge clk); #1;
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_sum", {55'd0, carry_out, sum}, {55'd0, exp});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("release_keep", {55'd0, carry_out, sum}, {55'd0, exp});
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, guard;
    logic [16:0] exp16;
    bit seen;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("rst_sum", {55'd0, carry_out, sum}, 64'd0);
    check("rst_flags16", {61'd0, in_ready16, out_valid16, busy16}, 64'b100);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plan 1-3
    run8(8'h35, 8'h4A, 1'b0, 1'b0, 0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    run8(8'h10, 8'h20, 1'b0, 1'b0, 5, 1'b1);
    run8(8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0);

    // Plan 4: reset at RUN slice 3
    a = 8'hAA; b = 8'h55; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("mid_rst_sum", {55'd0, carry_out, sum}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_valid_after_rst", {63'd0, seen}, 64'd0);
    run8(8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0);

    // Plan 6: subtract mode
    if (SUB_EN) begin
      run8(8'h05, 8'h03, 1'b0, 1'b1, 0, 1'b0);
      run8(8'h03, 8'h05, 1'b1, 1'b1, 0, 1'b0);
    end

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Plan 5: 16-bit, 4-bit slices, then a few random operands
    for (int t = 0; t < 6; t++) begin
      if (t == 0) begin
        a16 = 16'hFFFF; b16 = 16'h0001; c_in16 = 1'b0;
      end else begin
        a16 = 16'($urandom); b16 = 16'($urandom); c_in16 = 1'($urandom);
      end
      exp16 = {1'b0, a16} + {1'b0, b16} + {16'd0, c_in16};
      in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      check("latency16", 64'(lat), 64'd4);
      check("sum16", {47'd0, carry_out16, sum16}, {47'd0, exp16});
      guard = 0;
      while (!in_ready16 && guard < 10) begin
        @(posedge clk); #1; guard++;
      end
      check("idle16", {63'd0, in_ready16}, 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
